// File: rtl/cache_pkg.sv
// Shared types and helpers for the parametrised set-associative cache:
// FSM state encoding, width helpers and the true-LRU age update rule.
package cache_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL_REQ  = 3'd1,
        FILL_WAIT = 3'd2,
        WT_REQ    = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Index width that never collapses to zero bits (WAYS=1 still needs a way port).
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // New age of one way when way 'is_touched' (holding ref_age) becomes most recent.
    function automatic logic [3:0] age_next(input logic [3:0] age,
                                            input logic [3:0] ref_age,
                                            input logic       is_touched);
        logic [3:0] result;
        if (is_touched) begin
            result = 4'd0;
        end else if (age < ref_age) begin
            result = age + 4'd1;
        end else begin
            result = age;
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_lru_age.sv
// Per-set true-LRU age array: ages form a permutation of 0..WAYS-1 in every set,
// the oldest way (age WAYS-1) of the looked-up set is offered as replacement candidate.
module cache_lru_age
    import cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 64,
    parameter int IDX_W = 6,
    parameter int WAY_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    input  logic [WAY_W-1:0] touch_way,
    input  logic [IDX_W-1:0] look_idx,
    output logic [WAY_W-1:0] oldest_way
);

    localparam int AGE_W = WAY_W;

    logic [AGE_W-1:0] age_r [SETS][WAYS];
    logic [AGE_W-1:0] ref_age_s;

    assign ref_age_s = age_r[touch_idx][touch_way];

    // Age storage: reset/flush restore age[s][w]=w, a touch promotes one way to age 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_r[s][w] <= AGE_W'(w);
                end
            end
        end else if (init) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_r[s][w] <= AGE_W'(w);
                end
            end
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                age_r[touch_idx][w] <= AGE_W'(age_next(4'(age_r[touch_idx][w]), 4'(ref_age_s),
                                                       WAY_W'(w) == touch_way));
            end
        end
    end

    // Oldest-way search in the set currently being looked up.
    always_comb begin
        oldest_way = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            oldest_way = (age_r[look_idx][w] == AGE_W'(WAYS - 1)) ? WAY_W'(w) : oldest_way;
        end
    end

endmodule

// File: rtl/cache_sa_param.sv
// N-way set-associative write-through, write-allocate cache with block-fill miss FSM.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_sa_param
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WAYS   = 4,
    parameter int SETS   = 64,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int OFF_W  = $clog2(WORDS) + 1;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = clog2_min1(WAYS);
    localparam int BEAT_W = OFF_W - 1;

    state_t                 state_r;
    logic [DATA_W-1:0]      data_r  [SETS][WAYS][WORDS];
    logic [TAG_W-1:0]       tag_r   [SETS][WAYS];
    logic [WAYS-1:0]        valid_r [SETS];

    logic [TAG_W-1:0]       tag_s;
    logic [IDX_W-1:0]       idx_s;
    logic [BEAT_W-1:0]      word_s;
    logic                   addr_lsb_unused_s;
    logic                   hit_s;
    logic [WAY_W-1:0]       hit_way_s;
    logic                   inv_found_s;
    logic [WAY_W-1:0]       inv_way_s;
    logic [WAY_W-1:0]       lru_way_s;
    logic [WAY_W-1:0]       victim_s;
    logic [DATA_W-1:0]      hit_word_s;
    logic                   accept_s;
    logic                   flush_s;
    logic                   fill_beat_s;
    logic                   fill_last_s;
    logic                   touch_s;
    logic [IDX_W-1:0]       touch_idx_s;
    logic [WAY_W-1:0]       touch_way_s;

    logic                   rsp_valid_r;
    logic [DATA_W-1:0]      rsp_rdata_r;
    logic                   mem_req_r;
    logic                   mem_we_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [DATA_W-1:0]      mem_wdata_r;
    logic [BEAT_W-1:0]      beat_r;
    logic [WAY_W-1:0]       victim_r;
    logic [TAG_W-1:0]       tag_l_r;
    logic [IDX_W-1:0]       idx_l_r;
    logic [BEAT_W-1:0]      word_l_r;
    logic                   we_l_r;
    logic [DATA_W-1:0]      wdata_l_r;

    assign tag_s             = req_addr[ADDR_W-1:IDX_W+OFF_W];
    assign idx_s             = req_addr[IDX_W+OFF_W-1:OFF_W];
    assign word_s            = req_addr[OFF_W-1:1];
    assign addr_lsb_unused_s = req_addr[0];

    assign req_ready   = (state_r == IDLE) && !flush;
    assign accept_s    = (state_r == IDLE) && req_valid && !flush;
    assign flush_s     = (state_r == IDLE) && flush;
    assign fill_beat_s = (state_r == FILL_WAIT) && mem_rvalid;
    assign fill_last_s = fill_beat_s && (beat_r == BEAT_W'(WORDS - 1));
    assign hit_word_s  = data_r[idx_s][hit_way_s][word_s];

    assign touch_s     = (accept_s && hit_s) || fill_last_s;
    assign touch_idx_s = fill_last_s ? idx_l_r : idx_s;
    assign touch_way_s = fill_last_s ? victim_r : hit_way_s;

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // Tag compare and replacement choice; the lowest-index invalid way beats LRU.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = {WAY_W{1'b0}};
        inv_found_s = 1'b0;
        inv_way_s   = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s   = (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s)) ? WAY_W'(w) : hit_way_s;
            hit_s       = hit_s | (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s));
            inv_way_s   = !valid_r[idx_s][w] ? WAY_W'(w) : inv_way_s;
            inv_found_s = inv_found_s | !valid_r[idx_s][w];
        end
        victim_s = inv_found_s ? inv_way_s : lru_way_s;
    end

    cache_lru_age #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .init       (flush_s),
        .touch      (touch_s),
        .touch_idx  (touch_idx_s),
        .touch_way  (touch_way_s),
        .look_idx   (idx_s),
        .oldest_way (lru_way_s)
    );

    // Valid bits: the victim is invalidated at miss entry so an abandoned fill never leaves it valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= {WAYS{1'b0}};
            end
        end else if (flush_s) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= {WAYS{1'b0}};
            end
        end else if (accept_s && !hit_s) begin
            valid_r[idx_s][victim_s] <= 1'b0;
        end else if (fill_last_s) begin
            valid_r[idx_l_r][victim_r] <= 1'b1;
        end
    end

    // Tag and data arrays; on the last fill beat the pending store is merged after the beat write.
    always_ff @(posedge clk) begin
        if (accept_s && hit_s && req_we) begin
            data_r[idx_s][hit_way_s][word_s] <= req_wdata;
        end else if (fill_beat_s) begin
            data_r[idx_l_r][victim_r][beat_r] <= mem_rdata;
            if (fill_last_s) begin
                tag_r[idx_l_r][victim_r] <= tag_l_r;
                if (we_l_r) begin
                    data_r[idx_l_r][victim_r][word_l_r] <= wdata_l_r;
                end
            end
        end
    end

    // Control FSM with registered CPU response and memory request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 16'h0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 16'h0000;
            beat_r      <= {BEAT_W{1'b0}};
            victim_r    <= {WAY_W{1'b0}};
            tag_l_r     <= {TAG_W{1'b0}};
            idx_l_r     <= {IDX_W{1'b0}};
            word_l_r    <= {BEAT_W{1'b0}};
            we_l_r      <= 1'b0;
            wdata_l_r   <= 16'h0000;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && hit_s && req_we) begin
                        state_r     <= WT_REQ;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= {req_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata_r <= req_wdata;
                    end else if (accept_s && hit_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= hit_word_s;
                    end else if (accept_s) begin
                        state_r    <= FILL_REQ;
                        victim_r   <= victim_s;
                        tag_l_r    <= tag_s;
                        idx_l_r    <= idx_s;
                        word_l_r   <= word_s;
                        we_l_r     <= req_we;
                        wdata_l_r  <= req_wdata;
                        beat_r     <= {BEAT_W{1'b0}};
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {tag_s, idx_s, {BEAT_W{1'b0}}, 1'b0};
                    end
                end
                FILL_REQ: begin
                    if (mem_ready) begin
                        mem_req_r <= 1'b0;
                        state_r   <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_rvalid) begin
                        if (beat_r == word_l_r) begin
                            rsp_rdata_r <= mem_rdata;
                        end
                        if (fill_last_s && we_l_r) begin
                            beat_r      <= {BEAT_W{1'b0}};
                            state_r     <= WT_REQ;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= {tag_l_r, idx_l_r, word_l_r, 1'b0};
                            mem_wdata_r <= wdata_l_r;
                        end else if (fill_last_s) begin
                            beat_r      <= {BEAT_W{1'b0}};
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            beat_r     <= beat_r + BEAT_W'(1);
                            state_r    <= FILL_REQ;
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= {tag_l_r, idx_l_r, beat_r + BEAT_W'(1), 1'b0};
                        end
                    end
                end
                WT_REQ: begin
                    if (mem_ready) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] miss_cnt_r;

    // Saturating per-outcome request counters, cleared together with the cache contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else if (flush_s) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else if (accept_s && hit_s) begin
            if (hit_cnt_r != 16'hFFFF) begin
                hit_cnt_r <= hit_cnt_r + 16'd1;
            end
        end else if (accept_s) begin
            if (miss_cnt_r != 16'hFFFF) begin
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_cache_sa_param.sv
// Scoreboard bench for cache_sa_param: directed requests push expected memory beats
// and responses; a memory responder and a response monitor pop and compare them.
module tb_cache_sa_param;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        logic        chk;
        logic [15:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int    checks   = 0;
    int    failures = 0;
    int    rsp_count = 0;
    int    rd_beats  = 0;
    beat_t exp_mem_q [$];
    rsp_t  exp_rsp_q [$];
    logic [15:0] mem_wr [logic [15:0]];

    cache_sa_param dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] addr);
        return mem_wr.exists(addr) ? mem_wr[addr] : addr;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_fill(input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            exp_mem_q.push_back('{1'b0, base + 16'(2 * i), 16'h0000});
        end
    endtask

    task automatic push_rsp(input logic c, input logic [15:0] data);
        exp_rsp_q.push_back('{c, data});
    endtask

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic hit_load, input logic wait_rsp);
        int n;
        int cnt0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        cnt0 = rsp_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (hit_load) begin
            chk("hit_rsp_latency", 16'(rsp_valid), 16'h0001);
        end
        if (wait_rsp) begin
            n = 0;
            while (rsp_count == cnt0 && n < 400) begin
                @(posedge clk);
                n++;
            end
            checks++;
            if (rsp_count == cnt0) begin
                failures++;
                $display("FAIL rsp_timeout addr=%h", addr);
            end
            chk("beats_left", 16'(exp_mem_q.size()), 16'h0000);
        end
    endtask

    // Memory responder: accepts each request one cycle later, returns read data the cycle after.
    initial begin
        logic        pend;
        logic [15:0] pend_data;
        beat_t       e;
        pend = 1'b0;
        pend_data = 16'h0000;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ready  = 1'b0;
                mem_rvalid = 1'b0;
                pend       = 1'b0;
            end else begin
                mem_rvalid = pend;
                mem_rdata  = pend ? pend_data : 16'h0000;
                pend       = 1'b0;
                if (mem_ready) begin
                    mem_ready = 1'b0;
                end else if (mem_req) begin
                    mem_ready = 1'b1;
                    checks++;
                    if (exp_mem_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_mem_beat we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
                    end else begin
                        e = exp_mem_q.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                            failures++;
                            $display("FAIL mem_beat actual we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                    if (mem_we) begin
                        mem_wr[mem_addr] = mem_wdata;
                    end else begin
                        pend      = 1'b1;
                        pend_data = mem_rd(mem_addr);
                        rd_beats++;
                    end
                end
            end
        end
    end

    // Response monitor: every rsp_valid pulse consumes one expected response.
    always @(negedge clk) begin
        rsp_t r;
        if (rst && rsp_valid) begin
            rsp_count++;
            if (exp_rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp rdata=%h", rsp_rdata);
            end else begin
                r = exp_rsp_q.pop_front();
                if (r.chk) begin
                    chk("rsp_rdata", rsp_rdata, r.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b0;
        rst = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 16'h0000;
        req_wdata = 16'h0000;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk("rst_mem_req", 16'(mem_req), 16'h0000);
        chk("rst_mem_we", 16'(mem_we), 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_req_ready", 16'(req_ready), 16'h0001);
        @(negedge clk);
        rst = 1'b1;

        // Cold load, then hit in the same block.
        push_fill(16'h0410); push_rsp(1'b1, 16'h0412);
        do_req(1'b0, 16'h0412, 16'h0000, 1'b0, 1'b1);
        push_rsp(1'b1, 16'h0418);
        do_req(1'b0, 16'h0418, 16'h0000, 1'b1, 1'b1);

        // Store hit writes through, later load sees it without a fill.
        exp_mem_q.push_back('{1'b1, 16'h0412, 16'hBEEF}); push_rsp(1'b0, 16'h0000);
        do_req(1'b1, 16'h0412, 16'hBEEF, 1'b0, 1'b1);
        push_rsp(1'b1, 16'hBEEF);
        do_req(1'b0, 16'h0412, 16'h0000, 1'b1, 1'b1);

        // Five tags in set 1: tag 1 hits, tags 2..5 fill, tag 5 evicts tag 1.
        push_rsp(1'b1, 16'h0410);
        do_req(1'b0, 16'h0410, 16'h0000, 1'b1, 1'b1);
        push_fill(16'h0810); push_rsp(1'b1, 16'h0810);
        do_req(1'b0, 16'h0810, 16'h0000, 1'b0, 1'b1);
        push_fill(16'h0C10); push_rsp(1'b1, 16'h0C10);
        do_req(1'b0, 16'h0C10, 16'h0000, 1'b0, 1'b1);
        push_fill(16'h1010); push_rsp(1'b1, 16'h1010);
        do_req(1'b0, 16'h1010, 16'h0000, 1'b0, 1'b1);
        push_fill(16'h1410); push_rsp(1'b1, 16'h1410);
        do_req(1'b0, 16'h1410, 16'h0000, 1'b0, 1'b1);
        push_fill(16'h0410); push_rsp(1'b1, 16'hBEEF);
        do_req(1'b0, 16'h0412, 16'h0000, 1'b0, 1'b1);
        push_rsp(1'b1, 16'h1410);
        do_req(1'b0, 16'h1410, 16'h0000, 1'b1, 1'b1);

        // Store miss: fill then write-through, then hits.
        push_fill(16'h2000); exp_mem_q.push_back('{1'b1, 16'h2000, 16'h1234}); push_rsp(1'b0, 16'h0000);
        do_req(1'b1, 16'h2000, 16'h1234, 1'b0, 1'b1);
        push_rsp(1'b1, 16'h1234);
        do_req(1'b0, 16'h2000, 16'h0000, 1'b1, 1'b1);
        push_rsp(1'b1, 16'h2002);
        do_req(1'b0, 16'h2002, 16'h0000, 1'b1, 1'b1);

        // Flush invalidates everything; blocks the request port for that cycle.
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 16'(req_ready), 16'h0000);
        @(posedge clk);
        #1;
        flush = 1'b0;
        push_fill(16'h2000); push_rsp(1'b1, 16'h1234);
        do_req(1'b0, 16'h2000, 16'h0000, 1'b0, 1'b1);
        push_fill(16'h0410); push_rsp(1'b1, 16'h0418);
        do_req(1'b0, 16'h0418, 16'h0000, 1'b0, 1'b1);

        // Reset while waiting for fill beat 3, then refetch the same address.
        b0 = rd_beats;
        push_fill(16'h3000); push_rsp(1'b1, 16'h3006);
        do_req(1'b0, 16'h3006, 16'h0000, 1'b0, 1'b0);
        n = 0;
        while (rd_beats < b0 + 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("reset_beat_reached", 16'(rd_beats - b0), 16'h0004);
        #2;
        rst = 1'b0;
        #1;
        chk("midfill_rst_mem_req", 16'(mem_req), 16'h0000);
        chk("midfill_rst_mem_addr", mem_addr, 16'h0000);
        chk("midfill_rst_rsp_rdata", rsp_rdata, 16'h0000);
        exp_mem_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_fill(16'h3000); push_rsp(1'b1, 16'h3006);
        do_req(1'b0, 16'h3006, 16'h0000, 1'b0, 1'b1);
        push_fill(16'h2000); push_rsp(1'b1, 16'h1234);
        do_req(1'b0, 16'h2000, 16'h0000, 1'b0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        chk("mem_q_empty", 16'(exp_mem_q.size()), 16'h0000);
        chk("rsp_q_empty", 16'(exp_rsp_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
